// File: rtl/reg_wr_arbiter_if.sv
// rtl/reg_wr_arbiter_if.sv - requester and bank write-port signals of the register write arbiter
interface reg_wr_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
);
    logic [2:0]          req;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*DATA_W-1:0] req_data;
    logic [2:0]          ack;
    logic                err;
    logic                bank_ena_wr;
    logic [ADDR_W-1:0]   bank_addr;
    logic [DATA_W-1:0]   bank_data;
    logic                bank_wr_ack;
    logic                busy;
    logic [1:0]          state_out;

    // master: the requesters plus the register bank; slave: the arbiter
    modport master (
        output req, req_addr, req_data, bank_wr_ack,
        input  ack, err, bank_ena_wr, bank_addr, bank_data, busy, state_out
    );

    modport slave (
        input  req, req_addr, req_data, bank_wr_ack,
        output ack, err, bank_ena_wr, bank_addr, bank_data, busy, state_out
    );
endinterface

// File: rtl/reg_wr_arbiter.sv
// rtl/reg_wr_arbiter.sv - round-robin arbiter sharing the register bank write port among three requesters
module reg_wr_arbiter #(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    reg_wr_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit            TO_EN  = (TIMEOUT != 0);

    logic [1:0]        state;
    logic [1:0]        ptr;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic [TW-1:0]     timer;

    logic [1:0] cand;
    logic [1:0] win;
    logic       hit;

    // Scan ptr+1, ptr+2, ptr+3 (mod 3); the most recent winner is checked last.
    always_comb begin
        cand = ptr;
        win  = 2'd0;
        hit  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!hit && bus.req[cand]) begin
                win = cand;
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            ptr    <= 2'd2;
            grant  <= 2'd0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            timer  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hit) begin
                        grant  <= win;
                        addr_q <= bus.req_addr[win*ADDR_W +: ADDR_W];
                        data_q <= bus.req_data[win*DATA_W +: DATA_W];
                        timer  <= '0;
                        err_q  <= 1'b0;
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.bank_wr_ack) begin
                        err_q <= 1'b0;
                        state <= S_RESP;
                    end else if (TO_EN && (timer == T_LAST)) begin
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESP: begin
                    // Advancing the pointer even on timeout keeps a stuck bank from starving others.
                    ptr   <= grant;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.bank_ena_wr = (state == S_WRITE);
    assign bus.bank_addr   = addr_q;
    assign bus.bank_data   = data_q;
    assign bus.ack         = (state == S_RESP) ? (3'b001 << grant) : 3'b000;
    assign bus.err         = (state == S_RESP) && err_q;
    assign bus.busy        = (state != S_IDLE);
    assign bus.state_out   = state;
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb/tb_reg_wr_arbiter.sv - directed self-checking bench for reg_wr_arbiter
module tb_reg_wr_arbiter;
    localparam int DATA_W  = 4;
    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    bit   bank_auto = 1'b0;
    int   bank_delay = 0;
    int   ena_cnt = 0;
    logic auto_ack = 1'b0;
    logic man_ack = 1'b0;

    reg_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    reg_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.bank_wr_ack = bank_auto ? auto_ack : man_ack;

    // Bank model: acks once bank_ena_wr has been seen for more than bank_delay negedges
    always @(negedge clk) begin
        if (bank_auto && bus.bank_ena_wr) begin
            ena_cnt  = ena_cnt + 1;
            auto_ack = (ena_cnt > bank_delay);
        end else begin
            ena_cnt  = 0;
            auto_ack = 1'b0;
        end
    end

    task automatic do_reset;
        rst          = 1'b0;
        bus.req      = 3'b000;
        bus.req_addr = '0;
        bus.req_data = '0;
        bank_auto    = 1'b0;
        man_ack      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL reset_ack got=%0h exp=0", bus.ack); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", bus.err); end
        checks++; if (bus.bank_ena_wr !== 1'b0) begin failures++; $display("FAIL reset_ena got=%0h exp=0", bus.bank_ena_wr); end
        checks++; if (bus.bank_addr !== 2'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", bus.bank_addr); end
        checks++; if (bus.bank_data !== 4'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.bank_data); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
        checks++; if (bus.state_out !== 2'd0) begin failures++; $display("FAIL reset_state got=%0h exp=0", bus.state_out); end
        rst = 1'b1;
    endtask

    task automatic test_single;
        do_reset();
        bank_auto    = 1'b1;
        bank_delay   = 1;
        bus.req_addr = {2'd0, 2'd0, 2'd2};
        bus.req_data = {4'h0, 4'h0, 4'hA};
        bus.req      = 3'b001;
        @(negedge clk);
        checks++; if (bus.bank_ena_wr !== 1'b1) begin failures++; $display("FAIL single_ena1 got=%0h exp=1", bus.bank_ena_wr); end
        checks++; if (bus.bank_addr !== 2'd2) begin failures++; $display("FAIL single_addr got=%0h exp=2", bus.bank_addr); end
        checks++; if (bus.bank_data !== 4'hA) begin failures++; $display("FAIL single_data got=%0h exp=a", bus.bank_data); end
        checks++; if (bus.state_out !== 2'd1) begin failures++; $display("FAIL single_state_write got=%0h exp=1", bus.state_out); end
        checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL single_early_ack got=%0h exp=0", bus.ack); end
        @(negedge clk);
        checks++; if (bus.bank_ena_wr !== 1'b1) begin failures++; $display("FAIL single_ena2 got=%0h exp=1", bus.bank_ena_wr); end
        @(negedge clk);
        checks++; if (bus.ack !== 3'b001) begin failures++; $display("FAIL single_ack got=%0h exp=1", bus.ack); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL single_err got=%0h exp=0", bus.err); end
        checks++; if (bus.bank_ena_wr !== 1'b0) begin failures++; $display("FAIL single_ena_resp got=%0h exp=0", bus.bank_ena_wr); end
        checks++; if (bus.state_out !== 2'd2) begin failures++; $display("FAIL single_state_resp got=%0h exp=2", bus.state_out); end
        bus.req = 3'b000;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%0h exp=0", bus.busy); end
        checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL single_ack_end got=%0h exp=0", bus.ack); end
    endtask

    task automatic test_round_robin;
        logic [2:0]        acks[$];
        logic [ADDR_W-1:0] seen_addr[3];
        logic [DATA_W-1:0] seen_data[3];
        logic [2:0]        exp_ack[3];
        int   n_rise = 0;
        bit   prev_ena = 1'b0;
        bit   overlap = 1'b0;
        exp_ack[0] = 3'b001; exp_ack[1] = 3'b010; exp_ack[2] = 3'b100;
        do_reset();
        bank_auto    = 1'b1;
        bank_delay   = 0;
        bus.req_addr = {2'd3, 2'd2, 2'd1};
        bus.req_data = {4'h7, 4'h6, 4'h5};
        bus.req      = 3'b111;
        for (int cyc = 0; cyc < 40 && !(bus.req == 3'b000 && !bus.busy); cyc++) begin
            @(negedge clk);
            if (bus.bank_ena_wr && !prev_ena && n_rise < 3) begin
                seen_addr[n_rise] = bus.bank_addr;
                seen_data[n_rise] = bus.bank_data;
                n_rise++;
            end
            if (bus.bank_ena_wr && bus.ack != 3'b000) overlap = 1'b1;
            if (bus.ack != 3'b000) begin
                acks.push_back(bus.ack);
                bus.req = bus.req & ~bus.ack;
            end
            prev_ena = bus.bank_ena_wr;
        end
        bus.req = 3'b000;
        checks++; if (n_rise !== 3) begin failures++; $display("FAIL rr_grants got=%0d exp=3", n_rise); end
        checks++; if (overlap !== 1'b0) begin failures++; $display("FAIL rr_overlap got=%0d exp=0", overlap); end
        checks++; if (acks.size() !== 3) begin failures++; $display("FAIL rr_ack_count got=%0d exp=3", acks.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < acks.size()) begin
                checks++; if (acks[i] !== exp_ack[i]) begin failures++; $display("FAIL rr_order[%0d] got=%0h exp=%0h", i, acks[i], exp_ack[i]); end
            end
            if (i < n_rise) begin
                checks++; if (seen_addr[i] !== ADDR_W'(i + 1)) begin failures++; $display("FAIL rr_addr[%0d] got=%0h exp=%0h", i, seen_addr[i], i + 1); end
                checks++; if (seen_data[i] !== DATA_W'(i + 5)) begin failures++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", i, seen_data[i], i + 5); end
            end
        end
    endtask

    task automatic test_fairness;
        logic [2:0] acks[$];
        logic [2:0] exp_ack[3];
        bit raised = 1'b0;
        exp_ack[0] = 3'b001; exp_ack[1] = 3'b010; exp_ack[2] = 3'b001;
        do_reset();
        bank_auto  = 1'b1;
        bank_delay = 2;
        bus.req    = 3'b001;
        for (int cyc = 0; cyc < 60 && acks.size() < 3; cyc++) begin
            @(negedge clk);
            if (!raised && bus.bank_ena_wr) begin
                bus.req[1] = 1'b1;
                raised = 1'b1;
            end
            if (bus.ack != 3'b000) begin
                acks.push_back(bus.ack);
                if (bus.ack[1]) bus.req[1] = 1'b0;
            end
        end
        bus.req = 3'b000;
        checks++; if (acks.size() !== 3) begin failures++; $display("FAIL fair_ack_count got=%0d exp=3", acks.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < acks.size()) begin
                checks++; if (acks[i] !== exp_ack[i]) begin failures++; $display("FAIL fair_order[%0d] got=%0h exp=%0h", i, acks[i], exp_ack[i]); end
            end
        end
    endtask

    task automatic test_timeout;
        int         ena_cycles = 0;
        bit         got = 1'b0;
        logic [2:0] ack_v = 3'b000;
        logic       err_v = 1'b0;
        do_reset();
        bus.req_addr = {2'd0, 2'd1, 2'd3};
        bus.req      = 3'b011;
        for (int cyc = 0; cyc < 40 && !got; cyc++) begin
            @(negedge clk);
            if (bus.bank_ena_wr) ena_cycles++;
            if (bus.ack != 3'b000) begin
                got   = 1'b1;
                ack_v = bus.ack;
                err_v = bus.err;
                bus.req[0] = 1'b0;
            end
        end
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL to_no_ack got=%0d exp=1", got); end
        checks++; if (ena_cycles !== TIMEOUT) begin failures++; $display("FAIL to_ena_cycles got=%0d exp=%0d", ena_cycles, TIMEOUT); end
        checks++; if (ack_v !== 3'b001) begin failures++; $display("FAIL to_ack got=%0h exp=1", ack_v); end
        checks++; if (err_v !== 1'b1) begin failures++; $display("FAIL to_err got=%0h exp=1", err_v); end
        bank_auto  = 1'b1;
        bank_delay = 0;
        got = 1'b0;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            @(negedge clk);
            if (bus.ack != 3'b000) begin
                got   = 1'b1;
                ack_v = bus.ack;
                err_v = bus.err;
                bus.req = 3'b000;
            end
        end
        checks++; if (ack_v !== 3'b010) begin failures++; $display("FAIL to_next_ack got=%0h exp=2", ack_v); end
        checks++; if (err_v !== 1'b0) begin failures++; $display("FAIL to_next_err got=%0h exp=0", err_v); end
    endtask

    task automatic test_reset_mid_write;
        bit                got = 1'b0;
        logic [2:0]        ack_v = 3'b000;
        logic [ADDR_W-1:0] addr_v = '0;
        bit                addr_seen = 1'b0;
        int                stray = 0;
        do_reset();
        bank_auto    = 1'b1;
        bank_delay   = 0;
        bus.req_addr = {2'd3, 2'd2, 2'd1};
        bus.req      = 3'b010;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            @(negedge clk);
            if (bus.ack != 3'b000) begin got = 1'b1; bus.req = 3'b000; end
        end
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL rmw_setup_ack got=%0d exp=1", got); end
        @(negedge clk);
        bank_auto = 1'b0;
        bus.req   = 3'b100;
        repeat (3) @(negedge clk);
        checks++; if (bus.state_out !== 2'd1) begin failures++; $display("FAIL rmw_in_write got=%0h exp=1", bus.state_out); end
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.bank_ena_wr !== 1'b0) begin failures++; $display("FAIL rmw_ena got=%0h exp=0", bus.bank_ena_wr); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmw_busy got=%0h exp=0", bus.busy); end
        checks++; if (bus.state_out !== 2'd0) begin failures++; $display("FAIL rmw_state got=%0h exp=0", bus.state_out); end
        repeat (2) begin
            @(negedge clk);
            if (bus.ack != 3'b000) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL rmw_stray_ack got=%0d exp=0", stray); end
        rst        = 1'b1;
        bank_auto  = 1'b1;
        bank_delay = 0;
        bus.req    = 3'b111;
        got = 1'b0;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            @(negedge clk);
            if (bus.bank_ena_wr && !addr_seen) begin addr_v = bus.bank_addr; addr_seen = 1'b1; end
            if (bus.ack != 3'b000) begin got = 1'b1; ack_v = bus.ack; bus.req = 3'b000; end
        end
        checks++; if (ack_v !== 3'b001) begin failures++; $display("FAIL rmw_first_grant got=%0h exp=1", ack_v); end
        checks++; if (addr_v !== 2'd1) begin failures++; $display("FAIL rmw_first_addr got=%0h exp=1", addr_v); end
    endtask

    task automatic test_spurious;
        do_reset();
        bus.req_addr = {2'd0, 2'd3, 2'd2};
        bus.req_data = {4'h0, 4'hC, 4'h9};
        man_ack = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL sp_idle_busy got=%0h exp=0", bus.busy); end
        checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL sp_idle_ack got=%0h exp=0", bus.ack); end
        man_ack = 1'b0;
        bus.req = 3'b001;
        @(negedge clk);
        checks++; if (bus.state_out !== 2'd1) begin failures++; $display("FAIL sp_write got=%0h exp=1", bus.state_out); end
        man_ack = 1'b1;
        @(negedge clk);
        checks++; if (bus.ack !== 3'b001) begin failures++; $display("FAIL sp_ack0 got=%0h exp=1", bus.ack); end
        bus.req = 3'b000;
        @(negedge clk);
        checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL sp_resp_extra_ack got=%0h exp=0", bus.ack); end
        checks++; if (bus.state_out !== 2'd0) begin failures++; $display("FAIL sp_after_resp got=%0h exp=0", bus.state_out); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL sp_idle2_busy got=%0h exp=0", bus.busy); end
        man_ack = 1'b0;
        bus.req = 3'b010;
        @(negedge clk);
        checks++; if (bus.bank_addr !== 2'd3) begin failures++; $display("FAIL sp_next_addr got=%0h exp=3", bus.bank_addr); end
        checks++; if (bus.bank_data !== 4'hC) begin failures++; $display("FAIL sp_next_data got=%0h exp=c", bus.bank_data); end
        man_ack = 1'b1;
        @(negedge clk);
        checks++; if (bus.ack !== 3'b010) begin failures++; $display("FAIL sp_next_ack got=%0h exp=2", bus.ack); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL sp_next_err got=%0h exp=0", bus.err); end
        bus.req = 3'b000;
        man_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.req      = 3'b000;
        bus.req_addr = '0;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_timeout();
        test_reset_mid_write();
        test_spurious();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Shares the register bank's single write port among three requesters: req 0 = core FSM write-back, req 1 = debug/program loader, req 2 = I/O capture.
- Each requester uses a level-req / pulse-ack handshake.
- The arbiter grants one requester at a time in round-robin order, drives bank write-enable, address and data, waits for the bank's write ack, then returns a one-cycle ack to the winner.
- A bounded wait aborts a stuck bank write and flags an error.

Parameters:
- DATA_W, 4, register data width.
- ADDR_W, 2, register address width.
- TIMEOUT, 15, max WRITE-state cycles without bank_wr_ack before abort; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- req  input  3  request per requester, bit i = requester i
- req_addr  input  3*ADDR_W  flattened addresses, slice i = requester i
- req_data  input  3*DATA_W  flattened write data, slice i = requester i
- ack  output  3  one-cycle completion pulse to the granted requester
- err  output  1  high with ack when the write timed out
- bank_ena_wr  output  1  bank write enable (level)
- bank_addr  output  ADDR_W  bank write address
- bank_data  output  DATA_W  bank write data
- bank_wr_ack  input  1  bank write-done handshake
- busy  output  1  high in any state except IDLE
- state_out  output  2  encoded state for 7-segment display: IDLE=0, WRITE=1, RESP=2

Behaviour:
- Reset (async, rst low): state IDLE, ptr=2 (so requester 0 wins first), timer=0, latched grant/addr/data/err=0. All outputs 0: ack, err, bank_ena_wr, bank_addr, bank_data, busy, state_out.
- Outputs are Moore, decoded from state and latched registers only. No combinational path from req or bank_wr_ack to any output.
- IDLE:
  - If req != 0, pick the winner by scanning (ptr+1), (ptr+2), (ptr+3) mod 3; the first set bit wins.
  - Latch the winner index, req_addr slice and req_data slice; clear timer and err; go to WRITE.
  - If req == 0, stay in IDLE.
  - bank_wr_ack is ignored in IDLE.
- WRITE:
  - bank_ena_wr=1; bank_addr/bank_data = latched values, stable for the whole state.
  - bank_wr_ack=1: go to RESP, err_latch=0.
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1: go to RESP, err_latch=1.
  - Else timer+1, stay in WRITE.
- RESP:
  - ack[grant]=1 and err=err_latch for exactly one cycle; bank_ena_wr=0.
  - ptr <= grant; go to IDLE.
  - bank_wr_ack is ignored in RESP.
- Latency: req sampled high at edge N → bank_ena_wr high in cycle N+1. Bank ack at edge M → ack in cycle M+1. Minimum request-to-ack is 3 cycles.
- Requester rules:
  - Hold req high with addr/data stable until ack is seen.
  - Deassert req at the clock edge ending the ack cycle.
  - A req still high in the next IDLE cycle is treated as a new request.
  - addr/data changes after the IDLE sampling edge have no effect; values are latched.
- Simultaneous requests: exactly one grant per transaction. With all three held continuously, the grant order rotates 0,1,2,0,…
- Timeout write: the bank write is considered failed. The requester still receives ack with err=1 and the pointer still advances, so one stuck bank cannot starve the others.
- Reset mid-WRITE or mid-RESP: immediate return to the reset values. No ack is issued, and bank_ena_wr drops asynchronously.
- Illegal state encoding: next state is IDLE.

Test Plan:
- After reset, req=3'b001, addr0=2, data0=4'hA; bank acks 1 cycle after ena → bank_ena_wr=1 with addr=2, data=A in cycle 1; ack=3'b001 with err=0 in cycle 3; busy=0 in cycle 4.
- After reset, req=3'b111 held, requester dropping req after its ack, bank acking immediately → grant order 0,1,2. Each requester's addr/data appears on the bank port; 3 acks total; no overlap of bank_ena_wr between grants.
- Round-robin fairness: req0 held permanently, req1 raised once during the first grant → second grant goes to requester 1, not a repeated requester 0.
- Timeout: TIMEOUT=15, bank_wr_ack held 0 → bank_ena_wr high for exactly 15 cycles, then ack[grant]=1 with err=1. The next pending requester is served afterwards.
- Reset in the 3rd WRITE cycle → bank_ena_wr, busy and state_out are 0 immediately, and no ack appears. After release, req0 alone is granted first (ptr=2).
- Spurious bank_wr_ack pulses while in IDLE and during RESP → no state change, no extra ack; the subsequent transaction completes normally.
